// File: rtl/ski_mem_pkg.sv
// Shared constants, types and helpers for the SKI multi-core memory front end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: default parameter values, channel-index width helper, the
// request layout carried by the output stage, and the error flag value.
package ski_mem_pkg;

  localparam int N_CH_DEF      = 4;
  localparam int ADDR_W_DEF    = 32;
  localparam int DATA_W_DEF    = 32;
  localparam int MAX_OUTST_DEF = 4;

  // Value err_o takes once an unexpected read response has been seen.
  localparam logic ERR_UNEXP_RSP = 1'b1;

  // Width needed to hold a channel index; never below 1 so N_CH = 1 still
  // gets a real (constant zero) index signal.
  function automatic int ch_idx_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  // Request layout at default widths. The top re-declares the same field
  // order at its own parameterised widths.
  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/ski_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
// Latency: grant is combinational; pointer advances on the granting edge.
// Backpressure: en_i low suppresses any grant and freezes the pointer.
//
// Ports: system1000 / system1000_rst  clock, sync active-high reset
//        en_i       downstream can take a request this cycle
//        req_i      per-channel eligible requests
//        gnt_o      one-hot grant (or zero), gnt_vld_o any grant, gnt_idx_o index
module ski_rr_arbiter
  import ski_mem_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  localparam int CH_W = ch_idx_w(N_CH)
) (
  input  logic            system1000,
  input  logic            system1000_rst,
  input  logic            en_i,
  input  logic [N_CH-1:0] req_i,
  output logic [N_CH-1:0] gnt_o,
  output logic            gnt_vld_o,
  output logic [CH_W-1:0] gnt_idx_o
);

  logic [CH_W-1:0] ptr_q, ptr_d;
  logic            hit_hi, hit_any;
  logic [CH_W-1:0] idx_hi, idx_any;

  // Two searches: lowest requester at or above ptr (wraps to none), and
  // lowest requester overall. The first wins when present, otherwise the
  // search has wrapped past N_CH-1 and the overall lowest is next in turn.
  always_comb begin
    hit_hi  = 1'b0;
    hit_any = 1'b0;
    idx_hi  = '0;
    idx_any = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        hit_any = 1'b1;
        idx_any = CH_W'(k);
        if (k >= int'(ptr_q)) begin
          hit_hi = 1'b1;
          idx_hi = CH_W'(k);
        end
      end
    end
  end

  always_comb begin
    gnt_vld_o = en_i && hit_any;
    gnt_idx_o = hit_hi ? idx_hi : idx_any;
    gnt_o     = '0;
    ptr_d     = ptr_q;
    if (gnt_vld_o) begin
      gnt_o = N_CH'(1) << gnt_idx_o;
      ptr_d = (gnt_idx_o == CH_W'(N_CH - 1)) ? '0 : gnt_idx_o + CH_W'(1);
    end
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ski_mem_arbiter.sv
// Multi-core RAM front end: round-robin N_CH channels onto one RAM port, route reads back in order.
// Latency: grant -> ram_req_o 1 cycle; ram_rvalid_i -> ch_rvalid_o 1 cycle.
// Backpressure: single output register held while !ram_ready_i; reads also stall when MAX_OUTST are in flight.
//
// Ports: system1000 / system1000_rst            clock, sync active-high reset
//        ch_req_i/we_i/addr_i/wdata_i           per-channel requests, held until ch_grant_o
//        ch_grant_o                             one-hot combinational acceptance
//        ch_rvalid_o / ch_rdata_o               one-hot read strobe with shared data
//        ram_req_o/we_o/addr_o/wdata_o, ram_ready_i   RAM request handshake
//        ram_rvalid_i / ram_rdata_i             in-order RAM read responses
//        err_o                                  sticky: response arrived with nothing in flight
module ski_mem_arbiter
  import ski_mem_pkg::*;
#(
  parameter int N_CH      = N_CH_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_OUTST = MAX_OUTST_DEF
) (
  input  logic                     system1000,
  input  logic                     system1000_rst,
  input  logic [N_CH-1:0]          ch_req_i,
  input  logic [N_CH-1:0]          ch_we_i,
  input  logic [N_CH*ADDR_W-1:0]   ch_addr_i,
  input  logic [N_CH*DATA_W-1:0]   ch_wdata_i,
  output logic [N_CH-1:0]          ch_grant_o,
  output logic [N_CH-1:0]          ch_rvalid_o,
  output logic [DATA_W-1:0]        ch_rdata_o,
  output logic                     ram_req_o,
  output logic                     ram_we_o,
  output logic [ADDR_W-1:0]        ram_addr_o,
  output logic [DATA_W-1:0]        ram_wdata_o,
  input  logic                     ram_ready_i,
  input  logic                     ram_rvalid_i,
  input  logic [DATA_W-1:0]        ram_rdata_i,
  output logic                     err_o
);

  localparam int CH_W  = ch_idx_w(N_CH);
  localparam int PTR_W = $clog2(MAX_OUTST);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Output stage
  logic stg_vld_q, stg_vld_d;
  req_t stg_q, stg_d;

  // Tag FIFO: channel index of every read accepted but not yet answered
  logic [CH_W-1:0]  tag_mem_q [MAX_OUTST];
  logic [CH_W-1:0]  tag_mem_d [MAX_OUTST];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Response register
  logic              rsp_vld_q, rsp_vld_d;
  logic [CH_W-1:0]   rsp_idx_q, rsp_idx_d;
  logic [DATA_W-1:0] rsp_dat_q, rsp_dat_d;
  logic              err_q, err_d;

  logic            can_accept, pop, push, unexp, full_after_pop;
  logic [N_CH-1:0] eligible, gnt;
  logic            gnt_vld;
  logic [CH_W-1:0] gnt_idx;
  req_t            sel_req;

  // A response arriving this cycle frees a slot in time for a read granted
  // in the same cycle, so fullness is judged after the pop.
  always_comb begin
    pop            = ram_rvalid_i && (cnt_q != '0);
    unexp          = ram_rvalid_i && (cnt_q == '0);
    full_after_pop = (cnt_q == CNT_W'(MAX_OUTST)) && !pop;
    can_accept     = !stg_vld_q || ram_ready_i;
    eligible       = '0;
    for (int k = 0; k < N_CH; k++) begin
      eligible[k] = ch_req_i[k] && (ch_we_i[k] || !full_after_pop);
    end
  end

  ski_rr_arbiter #(
    .N_CH (N_CH)
  ) u_rr (
    .system1000     (system1000),
    .system1000_rst (system1000_rst),
    .en_i           (can_accept),
    .req_i          (eligible),
    .gnt_o          (gnt),
    .gnt_vld_o      (gnt_vld),
    .gnt_idx_o      (gnt_idx)
  );

  always_comb begin
    sel_req = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (gnt[k]) begin
        sel_req.we    = ch_we_i[k];
        sel_req.addr  = ch_addr_i[k*ADDR_W +: ADDR_W];
        sel_req.wdata = ch_wdata_i[k*DATA_W +: DATA_W];
      end
    end
    push = gnt_vld && !sel_req.we;
  end

  always_comb begin
    stg_vld_d = stg_vld_q;
    stg_d     = stg_q;
    tag_mem_d = tag_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    rsp_vld_d = pop;
    rsp_idx_d = rsp_idx_q;
    rsp_dat_d = rsp_dat_q;
    err_d     = err_q;

    if (gnt_vld) begin
      stg_vld_d = 1'b1;
      stg_d     = sel_req;
    end else if (ram_ready_i) begin
      stg_vld_d = 1'b0;
    end

    if (push) begin
      tag_mem_d[wr_ptr_q] = gnt_idx;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      rsp_idx_d = tag_mem_q[rd_ptr_q];
      rsp_dat_d = ram_rdata_i;
    end
    // Push with pop (including when full) leaves the count unchanged.
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    if (unexp) begin
      err_d = ERR_UNEXP_RSP;
    end
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      stg_vld_q <= 1'b0;
      stg_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rsp_vld_q <= 1'b0;
      rsp_idx_q <= '0;
      rsp_dat_q <= '0;
      err_q     <= 1'b0;
    end else begin
      stg_vld_q <= stg_vld_d;
      stg_q     <= stg_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_idx_q <= rsp_idx_d;
      rsp_dat_q <= rsp_dat_d;
      err_q     <= err_d;
    end
  end

  // Tag storage needs no reset: entries are only read below the count.
  always_ff @(posedge system1000) begin
    tag_mem_q <= tag_mem_d;
  end

  always_comb begin
    ch_grant_o  = gnt;
    ch_rvalid_o = '0;
    if (rsp_vld_q) begin
      ch_rvalid_o = N_CH'(1) << rsp_idx_q;
    end
    ch_rdata_o  = rsp_dat_q;
    ram_req_o   = stg_vld_q;
    ram_we_o    = stg_q.we;
    ram_addr_o  = stg_q.addr;
    ram_wdata_o = stg_q.wdata;
    err_o       = err_q;
  end

endmodule

// File: tb/tb_ski_mem_arbiter.sv
// Randomised bench for ski_mem_arbiter with a RAM model, a reference arbiter and a scoreboard.
// Latency: n/a.
// Backpressure: RAM model drops ram_ready_i randomly and returns reads after random delays.
module tb_ski_mem_arbiter;

  localparam int N_CH      = 4;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MAX_OUTST = 4;
  localparam int NCYC      = 2600;

  logic                   system1000 = 1'b0;
  logic                   system1000_rst;
  logic [N_CH-1:0]        ch_req_i, ch_we_i;
  logic [N_CH*ADDR_W-1:0] ch_addr_i;
  logic [N_CH*DATA_W-1:0] ch_wdata_i;
  logic [N_CH-1:0]        ch_grant_o, ch_rvalid_o;
  logic [DATA_W-1:0]      ch_rdata_o;
  logic                   ram_req_o, ram_we_o;
  logic [ADDR_W-1:0]      ram_addr_o;
  logic [DATA_W-1:0]      ram_wdata_o;
  logic                   ram_ready_i, ram_rvalid_i;
  logic [DATA_W-1:0]      ram_rdata_i;
  logic                   err_o;

  ski_mem_arbiter #(
    .N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .system1000(system1000), .system1000_rst(system1000_rst),
    .ch_req_i(ch_req_i), .ch_we_i(ch_we_i), .ch_addr_i(ch_addr_i), .ch_wdata_i(ch_wdata_i),
    .ch_grant_o(ch_grant_o), .ch_rvalid_o(ch_rvalid_o), .ch_rdata_o(ch_rdata_o),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_ready_i(ram_ready_i), .ram_rvalid_i(ram_rvalid_i), .ram_rdata_i(ram_rdata_i),
    .err_o(err_o)
  );

  always #5 system1000 = ~system1000;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Contents the RAM model returns for a read of address a.
  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  // Scoreboard: expected RAM requests {we, addr, wdata} and expected channel responses.
  logic [64:0] exp_req_q[$];
  int          exp_rsp_ch_q[$];
  logic [31:0] exp_rsp_dat_q[$];
  // RAM model: responses in issue order with the cycle they become due.
  int          ram_due_q[$];
  logic [31:0] ram_dat_q[$];

  // Stimulus, RAM model and reference arbiter
  initial begin
    logic [N_CH-1:0]   c_req, c_we, g_prev, exp_g;
    logic [ADDR_W-1:0] c_addr [N_CH];
    logic [DATA_W-1:0] c_wdata [N_CH];
    int   m_ptr, m_outst, last_due, due, lat, gk, kk;
    logic m_stage, m_err, m_rsp_vld, drain, rst_now, rst_prev, pop, can_acc, full_after, found;

    c_req = '0; c_we = '0; g_prev = '0;
    for (int k = 0; k < N_CH; k++) begin
      c_addr[k] = '0;
      c_wdata[k] = '0;
    end
    m_ptr = 0; m_outst = 0; last_due = -1; gk = 0; kk = 0;
    m_stage = 1'b0; m_err = 1'b0; m_rsp_vld = 1'b0; drain = 1'b1; rst_prev = 1'b1;
    system1000_rst = 1'b1;
    ch_req_i = '0; ch_we_i = '0; ch_addr_i = '0; ch_wdata_i = '0;
    ram_ready_i = 1'b1; ram_rvalid_i = 1'b0; ram_rdata_i = '0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge system1000);
      #1;
      rst_now = (cyc < 2) || (cyc == 8) || (cyc % 600 == 300);
      for (int k = 0; k < N_CH; k++) if (g_prev[k]) c_req[k] = 1'b0;
      if (rst_now) begin
        c_req = '0;
        drain = 1'b1;
      end else if (drain && cyc >= 12 && ram_due_q.size() == 0) begin
        drain = 1'b0;
      end
      if (!rst_now && !drain) begin
        for (int k = 0; k < N_CH; k++) begin
          if (!c_req[k] && $urandom_range(0, 1) == 1) begin
            c_req[k]   = 1'b1;
            c_we[k]    = ($urandom_range(0, 2) == 0);
            c_addr[k]  = $urandom_range(0, 65535);
            c_wdata[k] = $urandom;
          end
        end
      end
      for (int k = 0; k < N_CH; k++) begin
        ch_req_i[k] = c_req[k];
        ch_we_i[k]  = c_we[k];
        ch_addr_i[k*ADDR_W +: ADDR_W]  = c_addr[k];
        ch_wdata_i[k*DATA_W +: DATA_W] = c_wdata[k];
      end
      if (cyc < 12)                       ram_ready_i = 1'b1;
      else if (cyc >= 1000 && cyc < 1100) ram_ready_i = ($urandom_range(0, 7) == 0);
      else                                ram_ready_i = ($urandom_range(0, 3) != 0);
      if (cyc == 4) begin
        // Response with nothing in flight.
        ram_rvalid_i = 1'b1;
        ram_rdata_i  = $urandom;
      end else if (ram_due_q.size() > 0 && ram_due_q[0] <= cyc) begin
        ram_rvalid_i = 1'b1;
        ram_rdata_i  = ram_dat_q.pop_front();
        void'(ram_due_q.pop_front());
      end else begin
        ram_rvalid_i = 1'b0;
        ram_rdata_i  = $urandom;
      end
      system1000_rst = rst_now;

      @(negedge system1000);
      pop        = ram_rvalid_i && (m_outst > 0);
      can_acc    = !m_stage || ram_ready_i;
      full_after = (m_outst == MAX_OUTST) && !pop;
      found      = 1'b0;
      exp_g      = '0;
      if (can_acc) begin
        for (int i = 0; i < N_CH; i++) begin
          kk = (m_ptr + i) % N_CH;
          if (!found && ch_req_i[kk] && (ch_we_i[kk] || !full_after)) begin
            found = 1'b1;
            gk    = kk;
          end
        end
      end
      if (found) exp_g[gk] = 1'b1;

      check("grant", 64'(ch_grant_o), 64'(exp_g));
      check("ram_req", 64'(ram_req_o), 64'(m_stage));
      check("err", 64'(err_o), 64'(m_err));
      check("rsp_strobe", 64'(|ch_rvalid_o), 64'(m_rsp_vld));
      if (rst_prev && !rst_now) begin
        check("rst_rdata", 64'(ch_rdata_o), 64'd0);
        check("rst_ram_addr", 64'(ram_addr_o), 64'd0);
        check("rst_ram_wdata", 64'(ram_wdata_o), 64'd0);
        check("rst_ram_we", 64'(ram_we_o), 64'd0);
      end

      if (ram_req_o && ram_ready_i && !ram_we_o) begin
        lat = (cyc >= 1200 && cyc < 1400) ? $urandom_range(8, 16) : $urandom_range(1, 4);
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        ram_due_q.push_back(due);
        ram_dat_q.push_back(ram_word(ram_addr_o));
      end

      if (rst_now) begin
        m_ptr = 0; m_outst = 0; m_stage = 1'b0; m_err = 1'b0; m_rsp_vld = 1'b0;
        g_prev = '0;
        exp_req_q.delete();
        exp_rsp_ch_q.delete();
        exp_rsp_dat_q.delete();
      end else begin
        if (ram_rvalid_i && m_outst == 0) m_err = 1'b1;
        if (found) begin
          exp_req_q.push_back({c_we[gk], c_addr[gk], c_wdata[gk]});
          if (!c_we[gk]) begin
            exp_rsp_ch_q.push_back(gk);
            exp_rsp_dat_q.push_back(ram_word(c_addr[gk]));
            m_outst++;
          end
          m_ptr = (gk + 1) % N_CH;
        end
        if (pop) m_outst--;
        m_stage   = found || (m_stage && !ram_ready_i);
        m_rsp_vld = pop;
        g_prev    = exp_g;
      end
      rst_prev = rst_now;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Monitor: compares what the DUT presents against the scoreboard queues.
  initial begin
    logic            prev_stall, prev_rst;
    logic [64:0]     prev_pay, exp;
    logic [N_CH-1:0] oh;
    int              ch;
    logic [31:0]     d;
    prev_stall = 1'b0;
    prev_rst   = 1'b1;
    prev_pay   = '0;
    forever begin
      @(posedge system1000);
      #3;
      if (ch_rvalid_o != '0) begin
        if (exp_rsp_ch_q.size() == 0) begin
          check("rsp_spurious", 64'(ch_rvalid_o), 64'd0);
        end else begin
          ch = exp_rsp_ch_q.pop_front();
          d  = exp_rsp_dat_q.pop_front();
          oh = '0;
          oh[ch] = 1'b1;
          check("rsp_channel", 64'(ch_rvalid_o), 64'(oh));
          check("rsp_data", 64'(ch_rdata_o), 64'(d));
        end
      end
      if (prev_stall && !prev_rst) begin
        check("stall_req", 64'(ram_req_o), 64'd1);
        check("stall_addr", 64'(ram_addr_o), 64'(prev_pay[63:32]));
        check("stall_wdata", 64'(ram_wdata_o), 64'(prev_pay[31:0]));
      end
      if (ram_req_o && ram_ready_i) begin
        if (exp_req_q.size() == 0) begin
          check("req_spurious", 64'(ram_req_o), 64'd0);
        end else begin
          exp = exp_req_q.pop_front();
          check("req_we", 64'(ram_we_o), 64'(exp[64]));
          check("req_addr", 64'(ram_addr_o), 64'(exp[63:32]));
          if (exp[64]) check("req_wdata", 64'(ram_wdata_o), 64'(exp[31:0]));
        end
      end
      prev_stall = ram_req_o && !ram_ready_i;
      prev_pay   = {ram_we_o, ram_addr_o, ram_wdata_o};
      prev_rst   = system1000_rst;
    end
  end

endmodule
